exch_dir_ctrl: RTL
==================

// Module: exch_dir_ctrl
// PURPOSE
//  Direction arbiter/sequencer for the dual 32-bit bidirectional exchange (A<->B on oe0, C<->D on oe1).
//  Per channel, arbitrates A->B vs B->A requesters, drives the exchange direction enable and grants.
//  Inserts dead (turnaround) cycles so that no requester drives while the exchanger is reversing.
//  Bounds the hold time of a grant so both directions make progress.
// PARAMETERS
//  TURN_CYC  2   dead cycles between opposite-direction grants, legal range 1..2**CNT_W-1
//  MAX_HOLD  16  max consecutive grant cycles while the opposite side waits; 0 = unlimited
//  CNT_W     5   width of turn/hold counters; must hold TURN_CYC and MAX_HOLD
// PORTS
//  clk     in   1  single clock, all state on rising edge
//  rst     in   1  synchronous, active-high reset
//  req_ab  in   2  [0]: A->B request, [1]: C->D request; held until transfer done
//  req_ba  in   2  [0]: B->A request, [1]: D->C request
//  gnt_ab  out  2  per-channel grant for the forward (low-oe) direction, registered
//  gnt_ba  out  2  per-channel grant for the reverse (high-oe) direction, registered
//  oe0     out  1  to exchanger: 0 = A->B, 1 = B->A, registered
//  oe1     out  1  to exchanger: 0 = C->D, 1 = D->C, registered
//  turn    out  2  per-channel: 1 while in TURN state (debug/status)
// BEHAVIOUR
//  - Channels 0 and 1 are identical, fully independent FSMs; [n] indexes the channel; oe0/oe1 = oe[0]/oe[1].
//  - Reset (rst=1 at edge): state=IDLE, gnt_ab=gnt_ba=0, oe=0, turn=0, counters=0, last=BA. Mid-operation too.
//  - States: IDLE, OWN_AB, OWN_BA, TURN. Per channel exactly one of gnt_ab/gnt_ba may be 1, never both.
//  - gnt_ab=1 only in OWN_AB (oe=0); gnt_ba=1 only in OWN_BA (oe=1); both 0 in IDLE and TURN.
//  - IDLE: oe holds last value.
//     * only req_ab: oe=0 -> OWN_AB next cycle; oe=1 -> TURN (target AB).
//     * only req_ba: oe=1 -> OWN_BA next cycle; oe=0 -> TURN (target BA).
//     * both: target = direction opposite to 'last' (last served owner); TURN if oe differs, else own direct.
//  - Entering TURN: oe takes the target value on that same edge; tcnt loads TURN_CYC.
//     tcnt decrements each TURN cycle; when tcnt==1 -> OWN_target next edge.
//     => grant asserts exactly TURN_CYC cycles after oe changes; gnt low for all TURN cycles.
//     * target request drops during TURN: still complete TURN, then re-evaluate as IDLE (no grant).
//  - OWN_x: hcnt counts grant cycles (1 on first grant cycle, saturating). On each edge:
//     * own req=0 and opposite req=1 -> TURN (target opposite), last=x.
//     * own req=0 and opposite req=0 -> IDLE, last=x.
//     * own req=1, opposite req=1, MAX_HOLD!=0 and hcnt==MAX_HOLD -> TURN (forced release), last=x.
//     * else stay; grant held.
//     => with contention, grant is high for exactly MAX_HOLD cycles.
//  - Request/grant latency: same-direction request from IDLE = 1 cycle; opposite = 1+TURN_CYC cycles.
//  - turn[n] = (state==TURN), registered with state.
//  - Requests sampled only at clock edges; no combinational req->gnt path.
//  - Requester must tri-state its bus in the cycle after gnt deasserts; the controller does not check this.
// TESTING
//  1. rst=1 for 2 cycles, reqs random -> oe0=oe1=0, gnt_ab=gnt_ba=turn=0 on every cycle after the first edge.
//  2. After reset, req_ab[0]=1 at cycle 0 -> gnt_ab[0]=1 from cycle 1, oe0 stays 0, turn[0] never 1.
//  3. From IDLE oe0=0, req_ba[0]=1 at cycle 0, TURN_CYC=2 -> cycle1: oe0=1, turn=1; cycle2: turn=1; cycle3: gnt_ba[0]=1.
//  4. MAX_HOLD=4, req_ab[1]=req_ba[1]=1 held -> gnt_ab[1] high 4 cycles, 2 dead cycles, gnt_ba[1] high 4, repeating.
//  5. Ch0 in OWN_AB while ch1 reverses -> gnt_ab[0], oe0 unaffected; ch1 timing as in test 3.
//  6. rst asserted during ch0 TURN (oe0=1) -> next cycle state IDLE, oe0=0, gnt_* =0; req_ab[0] then granted in 1 cycle.

Source files
------------

// File: rtl/exch_dir_ctrl.sv
// Direction arbiter/sequencer for a dual bidirectional exchange (A<->B on oe0, C<->D on oe1).
// Two independent per-channel FSMs grant one direction at a time, with turnaround and bounded hold.
module exch_dir_ctrl #(
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_ab,
    input  logic [1:0] req_ba,
    output logic [1:0] gnt_ab,
    output logic [1:0] gnt_ba,
    output logic       oe0,
    output logic       oe1,
    output logic [1:0] turn
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN_AB = 2'd1,
        ST_OWN_BA = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_TURN_CYC = CNT_W'(TURN_CYC);
    localparam logic [CNT_W-1:0] L_MAX_HOLD = CNT_W'(MAX_HOLD);
    localparam logic             L_HOLD_EN  = (MAX_HOLD != 0);

    logic [1:0] w_oe;

    assign oe0 = w_oe[0];
    assign oe1 = w_oe[1];

    for (genvar n = 0; n < 2; n++) begin : g_ch
        state_t           r_state;
        logic             r_oe;
        logic             r_gnt_ab;
        logic             r_gnt_ba;
        logic             r_turn;
        logic             r_last;   // direction of the last owner: 0 = AB, 1 = BA
        logic             r_dir;    // direction being turned to, or currently owned
        logic [CNT_W-1:0] r_tcnt;
        logic [CNT_W-1:0] r_hcnt;

        logic w_any_req;
        logic w_tgt;
        logic w_own_req;
        logic w_opp_req;

        // Request decode: IDLE target choice and own/opposite request of r_dir
        always_comb begin
            w_any_req = req_ab[n] | req_ba[n];
            w_tgt     = 1'b0;
            w_own_req = 1'b0;
            w_opp_req = 1'b0;
            if (req_ab[n] && req_ba[n]) begin
                w_tgt = ~r_last;
            end else begin
                w_tgt = req_ba[n];
            end
            if (r_dir) begin
                w_own_req = req_ba[n];
                w_opp_req = req_ab[n];
            end else begin
                w_own_req = req_ab[n];
                w_opp_req = req_ba[n];
            end
        end

        // Channel FSM with registered grants, direction and turn status
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state  <= ST_IDLE;
                r_oe     <= 1'b0;
                r_gnt_ab <= 1'b0;
                r_gnt_ba <= 1'b0;
                r_turn   <= 1'b0;
                r_last   <= 1'b1;
                r_dir    <= 1'b0;
                r_tcnt   <= {CNT_W{1'b0}};
                r_hcnt   <= {CNT_W{1'b0}};
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_any_req && (r_oe == w_tgt)) begin
                            r_state  <= w_tgt ? ST_OWN_BA : ST_OWN_AB;
                            r_dir    <= w_tgt;
                            r_gnt_ab <= ~w_tgt;
                            r_gnt_ba <= w_tgt;
                            r_hcnt   <= CNT_W'(1);
                        end else if (w_any_req) begin
                            r_state <= ST_TURN;
                            r_dir   <= w_tgt;
                            r_oe    <= w_tgt;
                            r_turn  <= 1'b1;
                            r_tcnt  <= L_TURN_CYC;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_TURN: begin
                        if (r_tcnt == CNT_W'(1)) begin
                            r_turn <= 1'b0;
                            r_tcnt <= {CNT_W{1'b0}};
                            // A target that dropped its request mid-turn gets no grant
                            if (w_own_req) begin
                                r_state  <= r_dir ? ST_OWN_BA : ST_OWN_AB;
                                r_gnt_ab <= ~r_dir;
                                r_gnt_ba <= r_dir;
                                r_hcnt   <= CNT_W'(1);
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_tcnt <= r_tcnt - CNT_W'(1);
                        end
                    end
                    ST_OWN_AB, ST_OWN_BA: begin
                        if ((!w_own_req && w_opp_req) ||
                            (w_own_req && w_opp_req && L_HOLD_EN && (r_hcnt == L_MAX_HOLD))) begin
                            r_state  <= ST_TURN;
                            r_last   <= r_dir;
                            r_dir    <= ~r_dir;
                            r_oe     <= ~r_dir;
                            r_gnt_ab <= 1'b0;
                            r_gnt_ba <= 1'b0;
                            r_turn   <= 1'b1;
                            r_tcnt   <= L_TURN_CYC;
                            r_hcnt   <= {CNT_W{1'b0}};
                        end else if (!w_own_req) begin
                            r_state  <= ST_IDLE;
                            r_last   <= r_dir;
                            r_gnt_ab <= 1'b0;
                            r_gnt_ba <= 1'b0;
                            r_hcnt   <= {CNT_W{1'b0}};
                        end else if (r_hcnt != {CNT_W{1'b1}}) begin
                            r_hcnt <= r_hcnt + CNT_W'(1);
                        end else begin
                            r_hcnt <= r_hcnt;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_gnt_ab <= 1'b0;
                        r_gnt_ba <= 1'b0;
                        r_turn   <= 1'b0;
                    end
                endcase
            end
        end

        assign gnt_ab[n] = r_gnt_ab;
        assign gnt_ba[n] = r_gnt_ba;
        assign turn[n]   = r_turn;
        assign w_oe[n]   = r_oe;
    end

endmodule
